// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pattern_gen
//  Purpose  : VGA test-pattern source. Recovers pixel column/row from the
//             rising edges of the active-region sync levels and drives one of
//             several RGB test patterns. Sync levels are re-timed by two
//             clocks so they stay aligned with the registered pixel colour.
//  Ports    : CLK          pixel clock
//             RST_N        synchronous active-low reset
//             H_sync_in    1 = horizontal active region, 0 = blanking
//             V_sync_in    1 = vertical active region, 0 = blanking
//             Pattern_sel  requested pattern, taken only at frame start
//             H_sync_out   H_sync_in delayed two clocks
//             V_sync_out   V_sync_in delayed two clocks
//             Red/Grn/Blu  pixel colour aligned with H/V_sync_out
//  Revision : 1.0  initial release
// ============================================================================
module vga_pattern_gen #(
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int COLOR_BITS  = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  H_sync_in,
    input  logic                  V_sync_in,
    input  logic [2:0]            Pattern_sel,
    output logic                  H_sync_out,
    output logic                  V_sync_out,
    output logic [COLOR_BITS-1:0] Red,
    output logic [COLOR_BITS-1:0] Grn,
    output logic [COLOR_BITS-1:0] Blu
);

    localparam logic [9:0]            c_cnt_max  = 10'h3FF;
    localparam logic [9:0]            c_cols     = 10'(ACTIVE_COLS);
    localparam logic [9:0]            c_rows     = 10'(ACTIVE_ROWS);
    localparam logic [9:0]            c_last_col = 10'(ACTIVE_COLS - 1);
    localparam logic [9:0]            c_last_row = 10'(ACTIVE_ROWS - 1);
    localparam int                    c_bar_w    = ACTIVE_COLS / 8;
    localparam logic [COLOR_BITS-1:0] c_full     = '1;
    localparam logic [COLOR_BITS-1:0] c_zero     = '0;

    localparam logic [2:0] c_pat_black  = 3'd0;
    localparam logic [2:0] c_pat_white  = 3'd1;
    localparam logic [2:0] c_pat_bars   = 3'd2;
    localparam logic [2:0] c_pat_check  = 3'd3;
    localparam logic [2:0] c_pat_grad   = 3'd4;
    localparam logic [2:0] c_pat_border = 3'd5;

    // Stage-1 sync samples: h1/v1 current, h2/v2 one clock older.
    logic       r_h1, r_h2, r_v1, r_v2;
    logic [9:0] r_col, r_row;
    logic [2:0] r_pat;

    logic                  w_h_rise, w_v_rise;
    logic [9:0]            w_col_nxt, w_row_nxt;
    logic [2:0]            w_pat_nxt;
    logic                  w_vis;
    logic                  w_border;
    logic [2:0]            w_bar;
    logic [COLOR_BITS-1:0] w_red, w_grn, w_blu;

    assign w_h_rise = r_h1 & ~r_h2;
    assign w_v_rise = r_v1 & ~r_v2;

    // Counters saturate instead of wrapping so that a missing sync rise
    // parks the position outside the visible area and blanks the output.
    always_comb begin
        w_col_nxt = r_col;
        if (w_h_rise) begin
            w_col_nxt = 10'd0;
        end else if (r_col != c_cnt_max) begin
            w_col_nxt = r_col + 10'd1;
        end
    end

    // Frame start wins over line start so the first line of a frame is row 0.
    always_comb begin
        w_row_nxt = r_row;
        if (w_v_rise) begin
            w_row_nxt = 10'd0;
        end else if (w_h_rise && (r_row != c_cnt_max)) begin
            w_row_nxt = r_row + 10'd1;
        end
    end

    assign w_pat_nxt = w_v_rise ? Pattern_sel : r_pat;

    // r_col/r_row describe the pixel whose sync level currently sits in h2/v2.
    assign w_vis = r_h2 & r_v2 & (r_col < c_cols) & (r_row < c_rows);

    assign w_border = (r_col == 10'd0) | (r_col == c_last_col) |
                      (r_row == 10'd0) | (r_row == c_last_row);

    // Bar index by threshold comparison; the last threshold passed wins.
    always_comb begin
        w_bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (32'(r_col) >= 32'(i * c_bar_w)) begin
                w_bar = 3'(i);
            end
        end
    end

    always_comb begin
        w_red = c_zero;
        w_grn = c_zero;
        w_blu = c_zero;
        case (r_pat)
            c_pat_black: ;
            c_pat_white: begin
                w_red = c_full;
                w_grn = c_full;
                w_blu = c_full;
            end
            c_pat_bars: begin
                w_red = w_bar[0] ? c_full : c_zero;
                w_grn = w_bar[1] ? c_full : c_zero;
                w_blu = w_bar[2] ? c_full : c_zero;
            end
            c_pat_check: begin
                if (r_col[5] ^ r_row[5]) begin
                    w_red = c_full;
                    w_grn = c_full;
                    w_blu = c_full;
                end
            end
            c_pat_grad: begin
                w_red = r_col[6 +: COLOR_BITS];
                w_grn = r_row[5 +: COLOR_BITS];
            end
            c_pat_border: begin
                w_blu = c_full;
                if (w_border) begin
                    w_red = c_full;
                    w_grn = c_full;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_h1       <= 1'b0;
            r_h2       <= 1'b0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_col      <= c_cnt_max;
            r_row      <= c_cnt_max;
            r_pat      <= c_pat_black;
            H_sync_out <= 1'b0;
            V_sync_out <= 1'b0;
            Red        <= c_zero;
            Grn        <= c_zero;
            Blu        <= c_zero;
        end else begin
            r_h1       <= H_sync_in;
            r_h2       <= r_h1;
            r_v1       <= V_sync_in;
            r_v2       <= r_v1;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_pat      <= w_pat_nxt;
            H_sync_out <= r_h2;
            V_sync_out <= r_v2;
            Red        <= w_vis ? w_red : c_zero;
            Grn        <= w_vis ? w_grn : c_zero;
            Blu        <= w_vis ? w_blu : c_zero;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_pattern_gen
//  Purpose  : Self-checking bench for vga_pattern_gen. Every clock edge is
//             compared against a position/pattern reference model; selected
//             pixels are also checked against a table of fixed colours.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_pattern_gen;

    localparam int COLS = 640;
    localparam int ROWS = 480;
    localparam int CB   = 3;
    localparam int NSPOT = 27;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          h_in, v_in;
    logic [2:0]    psel;
    logic          h_out, v_out;
    logic [CB-1:0] red, grn, blu;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .ACTIVE_COLS (COLS),
        .ACTIVE_ROWS (ROWS),
        .COLOR_BITS  (CB)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .H_sync_in   (h_in),
        .V_sync_in   (v_in),
        .Pattern_sel (psel),
        .H_sync_out  (h_out),
        .V_sync_out  (v_out),
        .Red         (red),
        .Grn         (grn),
        .Blu         (blu)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a pixel is identified by the sample it came from.
    typedef struct {
        bit h;
        bit v;
        int col;
        int row;
    } smp_t;

    smp_t pipe[$];
    bit   m_prev_h, m_prev_v, m_vseen, m_pend;
    int   m_last_h, m_hcnt, m_pat;
    int   edge_k = 0;

    // Bench-side position bookkeeping for table lookups.
    int cur_col = 0, cur_row = 0, cur_tag = 0;
    bit cur_valid = 1'b0;
    int pos_q[$] = '{-1, -1};
    int cap[int];
    int nb_cnt = 0;
    bit run_mon = 1'b0;
    int run_len = 0;
    int rst_row = -1, rst_col = -1;

    typedef struct {
        int tag;
        int col;
        int row;
        int r;
        int g;
        int b;
    } spot_t;
    spot_t spots [NSPOT];

    function automatic void exp_rgb(input int pat, input int col, input int row,
                                    output int r, output int g, output int b);
        int bar;
        r = 0; g = 0; b = 0;
        case (pat)
            1: begin r = 7; g = 7; b = 7; end
            2: begin
                bar = col / (COLS / 8);
                r = (bar % 2 == 1) ? 7 : 0;
                g = ((bar / 2) % 2 == 1) ? 7 : 0;
                b = ((bar / 4) % 2 == 1) ? 7 : 0;
            end
            3: if (((col / 32) + (row / 32)) % 2 == 1) begin r = 7; g = 7; b = 7; end
            4: begin r = (col / 64) % 8; g = (row / 32) % 8; end
            5: begin
                b = 7;
                if (col == 0 || col == COLS - 1 || row == 0 || row == ROWS - 1) begin
                    r = 7; g = 7;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic check_int(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic model_edge(input bit rst);
        smp_t s, ns;
        int   er, eg, eb, key, got;
        bit   eh, ev, hr, vr;
        er = 0; eg = 0; eb = 0; eh = 1'b0; ev = 1'b0;
        s = '{h: 1'b0, v: 1'b0, col: 1023, row: 1023};
        if (rst) begin
            pipe.delete();
            pipe.push_back(s);
            pipe.push_back(s);
            m_prev_h = 1'b0; m_prev_v = 1'b0; m_vseen = 1'b0; m_pend = 1'b0;
            m_last_h = -1; m_hcnt = 0; m_pat = 0;
        end else begin
            if (pipe.size() > 0) s = pipe.pop_front();
            eh = s.h;
            ev = s.v;
            if (s.h && s.v && s.col < COLS && s.row < ROWS)
                exp_rgb(m_pat, s.col, s.row, er, eg, eb);
            if (m_pend) begin
                m_pat  = int'(psel);
                m_pend = 1'b0;
            end
            hr = h_in && !m_prev_h;
            vr = v_in && !m_prev_v;
            if (hr) m_last_h = edge_k;
            if (vr) begin
                m_vseen = 1'b1;
                m_hcnt  = 0;
                m_pend  = 1'b1;
            end else if (hr && m_hcnt < 1023) begin
                m_hcnt++;
            end
            ns.h   = h_in;
            ns.v   = v_in;
            ns.col = (m_last_h < 0) ? 1023 :
                     ((edge_k - m_last_h > 1023) ? 1023 : edge_k - m_last_h);
            ns.row = m_vseen ? m_hcnt : 1023;
            pipe.push_back(ns);
            m_prev_h = h_in;
            m_prev_v = v_in;
        end

        tests++;
        if (h_out !== eh || v_out !== ev || red !== 3'(er) || grn !== 3'(eg) || blu !== 3'(eb)) begin
            fails++;
            $display("FAIL edge %0d: got hs=%0b vs=%0b rgb=%0d,%0d,%0d want hs=%0b vs=%0b rgb=%0d,%0d,%0d",
                     edge_k, h_out, v_out, red, grn, blu, eh, ev, er, eg, eb);
        end

        key = pos_q.pop_front();
        pos_q.push_back(cur_valid ? (cur_tag * 1048576 + cur_row * 1024 + cur_col) : -1);
        got = int'(red) * 64 + int'(grn) * 8 + int'(blu);
        if (key >= 0) cap[key] = got;
        if (got != 0) nb_cnt++;
        if (run_mon) begin
            if (got == 8'o777) begin
                run_len++;
            end else if (run_len > 0) begin
                check_int("white_run_len", run_len, COLS);
                run_len = 0;
            end
        end
        edge_k++;
    endtask

    task automatic tick(input bit h, input bit v, input bit rst);
        @(negedge clk);
        h_in  = h;
        v_in  = v;
        rst_n = ~rst;
        @(posedge clk);
        #1;
        model_edge(rst);
    endtask

    task automatic run_line(input int hi, input int lo, input bit v, input int row, input int tag);
        for (int c = 0; c < hi; c++) begin
            cur_valid = (tag > 0);
            cur_tag   = tag;
            cur_col   = c;
            cur_row   = row;
            tick(1'b1, v, (row == rst_row) && (c == rst_col));
        end
        cur_valid = 1'b0;
        for (int c = 0; c < lo; c++) tick(1'b0, v, 1'b0);
    endtask

    task automatic frame(input int nlines, input int hi, input int lo, input int tag);
        run_line(hi, lo, 1'b0, -1, 0);
        for (int r = 0; r < nlines; r++) run_line(hi, lo, 1'b1, r, tag);
        run_line(hi, lo, 1'b0, -1, 0);
    endtask

    initial begin
        int hi, lo, n, key;
        spots = '{
            '{1, 639, 1, 7, 7, 7}, '{1, 640, 1, 0, 0, 0},
            '{2, 0, 10, 0, 0, 0},  '{2, 79, 10, 0, 0, 0},  '{2, 80, 10, 7, 0, 0},
            '{2, 159, 10, 7, 0, 0}, '{2, 160, 10, 0, 7, 0}, '{2, 240, 10, 7, 7, 0},
            '{2, 319, 10, 7, 7, 0}, '{2, 560, 10, 7, 7, 7}, '{2, 639, 10, 7, 7, 7},
            '{3, 31, 0, 0, 0, 0},  '{3, 32, 0, 7, 7, 7},   '{3, 32, 32, 0, 0, 0},
            '{3, 0, 32, 7, 7, 7},
            '{6, 5, 5, 0, 0, 7},   '{6, 639, 2, 7, 7, 7},  '{6, 0, 3, 7, 7, 7},
            '{6, 640, 3, 0, 0, 0},
            '{7, 0, 0, 7, 7, 7},   '{7, 5, 478, 0, 0, 7},  '{7, 5, 479, 7, 7, 7},
            '{7, 5, 480, 0, 0, 0},
            '{10, 5, 110, 7, 7, 7},
            '{11, 0, 0, 7, 7, 7},  '{11, 5, 5, 0, 0, 7},
            '{12, 5, 5, 7, 7, 7}
        };
        rst_n = 1'b0; h_in = 1'b0; v_in = 1'b0; psel = 3'd0;

        // Reset held with toggling inputs: all outputs zero.
        for (int i = 0; i < 4; i++) begin
            psel = 3'($urandom_range(0, 7));
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end

        // No V rise yet: output must stay black.
        psel   = 3'd1;
        nb_cnt = 0;
        for (int i = 0; i < 3; i++) run_line(30, 5, 1'b0, -1, 0);
        check_int("black_before_vrise", nb_cnt, 0);

        // Fully random inputs with occasional reset pulses.
        for (int i = 0; i < 200; i++) begin
            psel = 3'($urandom_range(0, 7));
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
        end

        // Random frame geometry with random mid-frame pattern requests.
        for (int f = 0; f < 2; f++) begin
            hi   = $urandom_range(8, 120);
            lo   = $urandom_range(1, 10);
            n    = $urandom_range(5, 40);
            psel = 3'($urandom_range(0, 7));
            run_line(hi, lo, 1'b0, -1, 0);
            for (int r = 0; r < n; r++) begin
                if ($urandom_range(0, 9) == 0) psel = 3'($urandom_range(0, 7));
                run_line(hi, lo, 1'b1, r, 0);
            end
        end

        // White with H held past the visible width.
        psel = 3'd1;
        run_line(660, 20, 1'b0, -1, 0);
        run_mon = 1'b1;
        for (int r = 0; r < 4; r++) run_line(660, 20, 1'b1, r, 1);
        run_line(660, 20, 1'b0, -1, 0);
        run_mon = 1'b0;

        psel = 3'd2; frame(12, 640, 16, 2);
        psel = 3'd3; frame(34, 40, 4, 3);
        psel = 3'd4; frame(70, 130, 4, 0);
        psel = 3'd5; frame(7, 660, 8, 6);
        psel = 3'd5; frame(490, 20, 4, 7);
        for (int p = 0; p < 3; p++) begin
            psel = (p == 0) ? 3'd0 : 3'(p + 5);
            frame(4, 16, 4, 0);
        end

        // Pattern request changes mid-frame; takes effect next frame.
        psel = 3'd1;
        run_line(20, 4, 1'b0, -1, 0);
        for (int r = 0; r < 120; r++) begin
            if (r == 100) psel = 3'd5;
            run_line(20, 4, 1'b1, r, 10);
        end
        run_line(20, 4, 1'b0, -1, 0);
        run_line(20, 4, 1'b0, -1, 0);
        for (int r = 0; r < 10; r++) run_line(20, 4, 1'b1, r, 11);
        run_line(20, 4, 1'b0, -1, 0);

        // One-cycle reset mid-line at col 300, row 200.
        psel    = 3'd1;
        rst_row = 200;
        rst_col = 300;
        run_line(10, 2, 1'b0, -1, 0);
        for (int r = 0; r < 200; r++) run_line(10, 2, 1'b1, r, 0);
        run_line(330, 8, 1'b1, 200, 0);
        for (int r = 201; r < 204; r++) run_line(10, 2, 1'b1, r, 0);
        rst_row = -1;
        rst_col = -1;
        frame(8, 10, 2, 12);

        // Long H with no rise and more lines than the row counter can hold.
        psel = 3'd1;
        run_line(4, 2, 1'b0, -1, 0);
        run_line(1200, 4, 1'b1, 0, 0);
        for (int r = 0; r < 1030; r++) run_line(2, 2, 1'b1, r, 0);
        run_line(4, 2, 1'b0, -1, 0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);

        // Fixed-colour spot checks.
        for (int i = 0; i < NSPOT; i++) begin
            key = spots[i].tag * 1048576 + spots[i].row * 1024 + spots[i].col;
            tests++;
            if (!cap.exists(key)) begin
                fails++;
                $display("FAIL spot tag%0d c%0d r%0d: got no sample, want rgb=%0d,%0d,%0d",
                         spots[i].tag, spots[i].col, spots[i].row, spots[i].r, spots[i].g, spots[i].b);
            end else if (cap[key] != spots[i].r * 64 + spots[i].g * 8 + spots[i].b) begin
                fails++;
                $display("FAIL spot tag%0d c%0d r%0d: got rgb=%0d,%0d,%0d want rgb=%0d,%0d,%0d",
                         spots[i].tag, spots[i].col, spots[i].row,
                         cap[key] / 64, (cap[key] / 8) % 8, cap[key] % 8,
                         spots[i].r, spots[i].g, spots[i].b);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
